// File: rtl/pipe_mips32_il.sv
// rtl/pipe_mips32_il.sv - 5-stage MIPS32 pipeline with RAW interlock and retire/stall counters
// Define MIPS_FWD_EN for EX operand forwarding with load-use-only stalls.
module pipe_mips32_il #(
    parameter int MEM_AW   = 10,
    parameter int CNT_W    = 16,
    parameter int RESET_PC = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stalls
);
    localparam int DEPTH = 1 << MEM_AW;

    localparam logic [5:0] OP_MUL  = 6'b000101;
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011;
    localparam logic [5:0] OP_SLT  = 6'b000100;
    localparam logic [5:0] OP_LW   = 6'b001000;
    localparam logic [5:0] OP_SW   = 6'b001001;
    localparam logic [5:0] OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_SUBI = 6'b001011;
    localparam logic [5:0] OP_SLTI = 6'b001100;
    localparam logic [5:0] OP_BNEZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ = 6'b001110;
    localparam logic [5:0] OP_HLT  = 6'b111111;

    logic [31:0]       Reg [0:31];
    logic [31:0]       Mem [0:DEPTH-1];
    logic [MEM_AW-1:0] PC;
    logic              HALTED;
    logic              stop_q;
    logic [CNT_W-1:0]  retired_q, stalls_q;

    logic              ifid_v_q;
    logic [31:0]       ifid_ir_q;
    logic [MEM_AW-1:0] ifid_npc_q;

    logic              idex_v_q, idex_wr_q;
    logic [5:0]        idex_op_q;
    logic [4:0]        idex_dst_q;
    logic [31:0]       idex_a_q, idex_b_q, idex_imm_q;
    logic [MEM_AW-1:0] idex_npc_q;
`ifdef MIPS_FWD_EN
    logic [4:0]        idex_rs_q, idex_rt_q;
`endif

    logic              exmem_v_q, exmem_wr_q;
    logic [5:0]        exmem_op_q;
    logic [4:0]        exmem_dst_q;
    logic [31:0]       exmem_alu_q, exmem_b_q;

    logic              memwb_v_q, memwb_wr_q;
    logic [5:0]        memwb_op_q;
    logic [4:0]        memwb_dst_q;
    logic [31:0]       memwb_res_q;

    logic [5:0]        id_op;
    logic [4:0]        id_rs, id_rt, id_rd, id_dst;
    logic [31:0]       id_imm, id_a, id_b;
    logic              id_is_r, id_is_imm, id_use_rs, id_use_rt, id_wr, id_hlt, id_stall;
    logic              wb_we, fetch_en;

    logic [31:0]       ex_a, ex_b, ex_alu;
    logic              ex_taken;
    logic [MEM_AW-1:0] ex_target;
    logic [31:0]       mem_res;

    assign id_op  = ifid_ir_q[31:26];
    assign id_rs  = ifid_ir_q[25:21];
    assign id_rt  = ifid_ir_q[20:16];
    assign id_rd  = ifid_ir_q[15:11];
    assign id_imm = {{16{ifid_ir_q[15]}}, ifid_ir_q[15:0]};
    assign wb_we  = memwb_v_q && memwb_wr_q && !HALTED;

    always_comb begin
        id_is_r   = (id_op <= OP_MUL);
        id_is_imm = (id_op == OP_ADDI) || (id_op == OP_SUBI) || (id_op == OP_SLTI);
        id_use_rs = id_is_r || id_is_imm || (id_op == OP_LW) || (id_op == OP_SW) ||
                    (id_op == OP_BNEZ) || (id_op == OP_BEQZ);
        id_use_rt = id_is_r || (id_op == OP_SW);
        id_dst    = id_is_r ? id_rd : id_rt;
        id_wr     = (id_is_r || id_is_imm || (id_op == OP_LW)) && (id_dst != 5'd0);
        id_hlt    = ifid_v_q && (id_op == OP_HLT);

        // Register read with write-through of the value retiring this cycle
        if (id_rs == 5'd0)                          id_a = 32'd0;
        else if (wb_we && memwb_dst_q == id_rs)     id_a = memwb_res_q;
        else                                        id_a = Reg[id_rs];
        if (id_rt == 5'd0)                          id_b = 32'd0;
        else if (wb_we && memwb_dst_q == id_rt)     id_b = memwb_res_q;
        else                                        id_b = Reg[id_rt];

`ifdef MIPS_FWD_EN
        id_stall = ifid_v_q && idex_v_q && idex_wr_q && (idex_op_q == OP_LW) &&
                   ((id_use_rs && idex_dst_q == id_rs) || (id_use_rt && idex_dst_q == id_rt));
`else
        id_stall = ifid_v_q && (
            (idex_v_q && idex_wr_q &&
             ((id_use_rs && idex_dst_q == id_rs) || (id_use_rt && idex_dst_q == id_rt))) ||
            (exmem_v_q && exmem_wr_q &&
             ((id_use_rs && exmem_dst_q == id_rs) || (id_use_rt && exmem_dst_q == id_rt))));
`endif
    end

    always_comb begin
        ex_a = idex_a_q;
        ex_b = idex_b_q;
`ifdef MIPS_FWD_EN
        if (exmem_v_q && exmem_wr_q && exmem_dst_q == idex_rs_q)      ex_a = exmem_alu_q;
        else if (memwb_v_q && memwb_wr_q && memwb_dst_q == idex_rs_q) ex_a = memwb_res_q;
        if (exmem_v_q && exmem_wr_q && exmem_dst_q == idex_rt_q)      ex_b = exmem_alu_q;
        else if (memwb_v_q && memwb_wr_q && memwb_dst_q == idex_rt_q) ex_b = memwb_res_q;
`endif
        case (idex_op_q)
            OP_ADD:         ex_alu = ex_a + ex_b;
            OP_SUB:         ex_alu = ex_a - ex_b;
            OP_AND:         ex_alu = ex_a & ex_b;
            OP_OR:          ex_alu = ex_a | ex_b;
            OP_SLT:         ex_alu = ($signed(ex_a) < $signed(ex_b)) ? 32'd1 : 32'd0;
            OP_MUL:         ex_alu = ex_a * ex_b;
            OP_LW, OP_SW,
            OP_ADDI:        ex_alu = ex_a + idex_imm_q;
            OP_SUBI:        ex_alu = ex_a - idex_imm_q;
            OP_SLTI:        ex_alu = ($signed(ex_a) < $signed(idex_imm_q)) ? 32'd1 : 32'd0;
            default:        ex_alu = 32'd0;
        endcase
        ex_taken  = idex_v_q && (((idex_op_q == OP_BNEZ) && (ex_a != 32'd0)) ||
                                 ((idex_op_q == OP_BEQZ) && (ex_a == 32'd0)));
        ex_target = idex_npc_q + idex_imm_q[MEM_AW-1:0];
    end

    assign mem_res  = (exmem_op_q == OP_LW) ? Mem[exmem_alu_q[MEM_AW-1:0]] : exmem_alu_q;
    assign fetch_en = !stop_q && !id_hlt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC        <= MEM_AW'(RESET_PC);
            HALTED    <= 1'b0;
            stop_q    <= 1'b0;
            ifid_v_q  <= 1'b0;
            idex_v_q  <= 1'b0;
            exmem_v_q <= 1'b0;
            memwb_v_q <= 1'b0;
            retired_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (ex_taken) begin
                PC       <= ex_target;
                ifid_v_q <= 1'b0;
                idex_v_q <= 1'b0;
            end else if (id_stall) begin
                idex_v_q <= 1'b0;
            end else begin
                idex_v_q <= ifid_v_q;
                ifid_v_q <= fetch_en;
                if (fetch_en) PC <= PC + MEM_AW'(1);
                if (id_hlt)   stop_q <= 1'b1;
            end
            exmem_v_q <= idex_v_q;
            memwb_v_q <= exmem_v_q;
            if (memwb_v_q && memwb_op_q == OP_HLT) HALTED <= 1'b1;
            if (!HALTED) begin
                if (memwb_v_q && retired_q != {CNT_W{1'b1}})
                    retired_q <= retired_q + 1'b1;
                if (id_stall && !ex_taken && stalls_q != {CNT_W{1'b1}})
                    stalls_q <= stalls_q + 1'b1;
            end
        end
    end

    // Datapath payload and storage carry no reset; validity lives in the *_v_q bits
    always_ff @(posedge clk) begin
        if (!ex_taken && !id_stall && fetch_en) begin
            ifid_ir_q  <= Mem[PC];
            ifid_npc_q <= PC + MEM_AW'(1);
        end
        idex_op_q   <= id_op;
        idex_dst_q  <= id_dst;
        idex_wr_q   <= id_wr;
        idex_a_q    <= id_a;
        idex_b_q    <= id_b;
        idex_imm_q  <= id_imm;
        idex_npc_q  <= ifid_npc_q;
`ifdef MIPS_FWD_EN
        idex_rs_q   <= id_rs;
        idex_rt_q   <= id_rt;
`endif
        exmem_op_q  <= idex_op_q;
        exmem_dst_q <= idex_dst_q;
        exmem_wr_q  <= idex_wr_q;
        exmem_alu_q <= ex_alu;
        exmem_b_q   <= ex_b;
        memwb_op_q  <= exmem_op_q;
        memwb_dst_q <= exmem_dst_q;
        memwb_wr_q  <= exmem_wr_q;
        memwb_res_q <= mem_res;
        if (exmem_v_q && exmem_op_q == OP_SW && !HALTED)
            Mem[exmem_alu_q[MEM_AW-1:0]] <= exmem_b_q;
        if (wb_we)
            Reg[memwb_dst_q] <= memwb_res_q;
    end

    assign halted  = HALTED;
    assign retired = retired_q;
    assign stalls  = stalls_q;
endmodule
